melody_player: RTL and testbench

Sequencer that sits directly upstream of the speaker/tone path. On a start pulse it steps through a fixed 14-note melody held in an internal ROM. For each note it presents the tone divider `note_div` for a programmable number of beats, then a short silent gap. Its `note_div` output drives the note generator's divider input, which then feeds the I2S speaker controller.

---
 rtl/melody_player.sv | 220 ++++++++++++++++++++++
 tb/tb_melody_player.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/melody_player.sv
`default_nettype none
// ============================================================================
// Module      : melody_player
// Description : Steps through a fixed 14-note melody held in an internal ROM.
//               Each note drives a nonzero tone divider for beats*BEAT_CYCLES
//               cycles and is followed by GAP_CYCLES cycles of silence
//               (note_div = 0). note_div feeds the note generator's divider.
// Ports       : clk      - only clock
//               rst      - asynchronous reset, active low
//               start    - begin playback (sampled only while idle)
//               abort    - stop playback at the next edge, from any state
//               note_div - divider for the current tone, 0 = silence
//               note_idx - ROM index of the current note (0..13)
//               busy     - high while playing a note or its gap
//               done     - one-cycle pulse when the melody completes
// Options     : MELODY_LOOP_EN - when defined, playback wraps from the last
//               note back to the first; done is never asserted.
// Revision    : 1.0 - initial release
// ============================================================================
module melody_player #(
    parameter int BEAT_CYCLES = 25_000_000,
    parameter int GAP_CYCLES  = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        abort,
    output logic [21:0] note_div,
    output logic [3:0]  note_idx,
    output logic        busy,
    output logic        done
);

    // One cycle counter is shared by PLAY and GAP, so it is sized for the
    // larger of the two periods.
    localparam int c_CNT_MAX = (BEAT_CYCLES > GAP_CYCLES) ? BEAT_CYCLES : GAP_CYCLES;
    localparam int c_CNT_W   = (c_CNT_MAX > 1) ? $clog2(c_CNT_MAX) : 1;
    localparam logic [c_CNT_W-1:0] c_BEAT_LAST = c_CNT_W'(BEAT_CYCLES - 1);
    localparam logic [c_CNT_W-1:0] c_GAP_LAST  = c_CNT_W'(GAP_CYCLES - 1);
    localparam logic [3:0]         c_LAST_IDX  = 4'd13;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_PLAY = 2'd1,
        ST_GAP  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    // Melody ROM, split into tone code and beat count.
    function automatic logic [2:0] rom_code(input logic [3:0] idx);
        case (idx)
            4'd0, 4'd1, 4'd13:   rom_code = 3'd1;   // C
            4'd2, 4'd3, 4'd6:    rom_code = 3'd5;   // G
            4'd4, 4'd5:          rom_code = 3'd6;   // A
            4'd7, 4'd8:          rom_code = 3'd4;   // F
            4'd9, 4'd10:         rom_code = 3'd3;   // E
            4'd11, 4'd12:        rom_code = 3'd2;   // D
            default:             rom_code = 3'd0;   // rest
        endcase
    endfunction

    function automatic logic [1:0] rom_beats(input logic [3:0] idx);
        case (idx)
            4'd6, 4'd13: rom_beats = 2'd2;
            default:     rom_beats = 2'd1;
        endcase
    endfunction

    function automatic logic [21:0] code_to_div(input logic [2:0] code);
        case (code)
            3'd1:    code_to_div = 22'd95420;
            3'd2:    code_to_div = 22'd85034;
            3'd3:    code_to_div = 22'd75758;
            3'd4:    code_to_div = 22'd71633;
            3'd5:    code_to_div = 22'd63776;
            3'd6:    code_to_div = 22'd56818;
            3'd7:    code_to_div = 22'd50607;
            default: code_to_div = 22'd0;
        endcase
    endfunction

    state_t               r_state;
    state_t               w_state_next;
    logic [c_CNT_W-1:0]   r_cyc;
    logic [c_CNT_W-1:0]   w_cyc_next;
    logic [1:0]           r_beat;
    logic [1:0]           w_beat_next;
    logic [21:0]          r_note_div;
    logic [21:0]          w_div_next;
    logic [3:0]           r_note_idx;
    logic [3:0]           w_idx_next;
    logic                 r_busy;
    logic                 w_busy_next;
    logic                 r_done;
    logic                 w_done_next;

    logic [1:0]           w_cur_beats;
    logic [3:0]           w_nxt_idx;
    logic [21:0]          w_nxt_div;
    logic [21:0]          w_first_div;
    logic                 w_last_beat;

    assign w_cur_beats = rom_beats(r_note_idx);
    assign w_nxt_idx   = (r_note_idx == c_LAST_IDX) ? 4'd0 : r_note_idx + 4'd1;
    assign w_nxt_div   = code_to_div(rom_code(w_nxt_idx));
    assign w_first_div = code_to_div(rom_code(4'd0));
    // True on the final beat of the current note (beat counter about to reach
    // the note's beat count).
    assign w_last_beat = ({1'b0, r_beat} + 3'd1) == {1'b0, w_cur_beats};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= '0;
            r_beat     <= '0;
            r_note_div <= '0;
            r_note_idx <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
        end else begin
            r_state    <= w_state_next;
            r_cyc      <= w_cyc_next;
            r_beat     <= w_beat_next;
            r_note_div <= w_div_next;
            r_note_idx <= w_idx_next;
            r_busy     <= w_busy_next;
            r_done     <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_cyc_next   = r_cyc;
        w_beat_next  = r_beat;
        w_div_next   = r_note_div;
        w_idx_next   = r_note_idx;

        if (abort) begin
            w_state_next = ST_IDLE;
            w_cyc_next   = '0;
            w_beat_next  = '0;
            w_div_next   = '0;
            w_idx_next   = '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_cyc_next  = '0;
                    w_beat_next = '0;
                    w_div_next  = '0;
                    w_idx_next  = '0;
                    if (start) begin
                        w_state_next = ST_PLAY;
                        w_div_next   = w_first_div;
                    end
                end
                ST_PLAY: begin
                    if (r_cyc == c_BEAT_LAST) begin
                        w_cyc_next = '0;
                        if (w_last_beat) begin
                            w_state_next = ST_GAP;
                            w_beat_next  = '0;
                            w_div_next   = '0;
                        end else begin
                            w_beat_next = r_beat + 2'd1;
                        end
                    end else begin
                        w_cyc_next = r_cyc + 1'b1;
                    end
                end
                ST_GAP: begin
                    if (r_cyc == c_GAP_LAST) begin
                        w_cyc_next  = '0;
                        w_beat_next = '0;
`ifdef MELODY_LOOP_EN
                        w_state_next = ST_PLAY;
                        w_idx_next   = w_nxt_idx;
                        w_div_next   = w_nxt_div;
`else
                        if (r_note_idx == c_LAST_IDX) begin
                            w_state_next = ST_DONE;
                        end else begin
                            w_state_next = ST_PLAY;
                            w_idx_next   = w_nxt_idx;
                            w_div_next   = w_nxt_div;
                        end
`endif
                    end else begin
                        w_cyc_next = r_cyc + 1'b1;
                    end
                end
                ST_DONE: begin
                    // note_idx holds 13 during the done pulse, then clears.
                    w_state_next = ST_IDLE;
                    w_cyc_next   = '0;
                    w_beat_next  = '0;
                    w_div_next   = '0;
                    w_idx_next   = '0;
                end
                default: begin
                    w_state_next = ST_IDLE;
                    w_cyc_next   = '0;
                    w_beat_next  = '0;
                    w_div_next   = '0;
                    w_idx_next   = '0;
                end
            endcase
        end

        // Status flags are registered views of the state being entered.
        w_busy_next = (w_state_next == ST_PLAY) || (w_state_next == ST_GAP);
        w_done_next = (w_state_next == ST_DONE);
    end

    assign note_div = r_note_div;
    assign note_idx = r_note_idx;
    assign busy     = r_busy;
    assign done     = r_done;

endmodule
`default_nettype wire

// File: tb/tb_melody_player.sv
`default_nettype none
// ============================================================================
// Module      : tb_melody_player
// Description : Self-checking bench for melody_player with BEAT_CYCLES=4 and
//               GAP_CYCLES=2. Expected per-cycle outputs come from a timeline
//               built from the melody table and are queued as stimulus is
//               driven, then popped and compared one cycle later.
//               Define MELODY_LOOP_EN to build and check the looping variant.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_melody_player;

    localparam int BEAT = 4;
    localparam int GAP  = 2;
    localparam int NMAX = 110;

    logic        clk   = 1'b0;
    logic        rst   = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [21:0] note_div;
    logic [3:0]  note_idx;
    logic        busy;
    logic        done;

    melody_player #(
        .BEAT_CYCLES (BEAT),
        .GAP_CYCLES  (GAP)
    ) u_dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .abort    (abort),
        .note_div (note_div),
        .note_idx (note_idx),
        .busy     (busy),
        .done     (done)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [21:0] div;
        logic [3:0]  idx;
        logic        busy;
        logic        done;
    } exp_t;

    int   n_total = 0;
    int   n_bad   = 0;
    exp_t sb[$];
    exp_t tl[0:NMAX];

    int mel_div[14]   = '{95420, 95420, 63776, 63776, 56818, 56818, 63776,
                          71633, 71633, 75758, 75758, 85034, 85034, 95420};
    int mel_beats[14] = '{1, 1, 1, 1, 1, 1, 2, 1, 1, 1, 1, 1, 1, 2};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic exp_t mk(input int d, input int i, input bit b, input bit dn);
        exp_t e;
        e.div  = 22'(d);
        e.idx  = 4'(i);
        e.busy = b;
        e.done = dn;
        return e;
    endfunction

    // Expected outputs for cycle c after the start edge (tl[1] = cycle 1).
    task automatic build_timeline(input bit loop_en);
        int c;
        c = 1;
        tl[0] = mk(0, 0, 0, 0);
        while (c <= NMAX) begin
            for (int i = 0; i < 14; i++) begin
                for (int j = 0; j < mel_beats[i] * BEAT; j++) begin
                    if (c <= NMAX) tl[c] = mk(mel_div[i], i, 1, 0);
                    c++;
                end
                for (int j = 0; j < GAP; j++) begin
                    if (c <= NMAX) tl[c] = mk(0, i, 1, 0);
                    c++;
                end
            end
            if (!loop_en) begin
                if (c <= NMAX) tl[c] = mk(0, 13, 0, 1);
                c++;
                while (c <= NMAX) begin
                    tl[c] = mk(0, 0, 0, 0);
                    c++;
                end
            end
        end
    endtask

    task automatic pop_check(input string ctx);
        exp_t e;
        if (sb.size() == 0) begin
            chk({ctx, ".sb_underflow"}, 32'd1, 32'd0);
        end else begin
            e = sb.pop_front();
            chk({ctx, ".div"},  32'(note_div), 32'(e.div));
            chk({ctx, ".idx"},  32'(note_idx), 32'(e.idx));
            chk({ctx, ".busy"}, 32'(busy),     32'(e.busy));
            chk({ctx, ".done"}, 32'(done),     32'(e.done));
        end
    endtask

    task automatic check_zero(input string ctx);
        chk({ctx, ".div"},  32'(note_div), 32'd0);
        chk({ctx, ".idx"},  32'(note_idx), 32'd0);
        chk({ctx, ".busy"}, 32'(busy),     32'd0);
        chk({ctx, ".done"}, 32'(done),     32'd0);
    endtask

    // Starts playback (start high into edge 0) and checks cycles 1..ncyc.
    // abort_cyc / ex1 / ex2 are cycles in which abort or a stray start is held.
    task automatic run(input int ncyc, input int abort_cyc, input int ex1,
                       input int ex2, input string ctx);
        bit aborted;
        aborted = 1'b0;
        start = 1'b1;
        sb.push_back(tl[1]);
        @(posedge clk); #1;
        start = 1'b0;
        pop_check(ctx);
        for (int k = 1; k < ncyc; k++) begin
            start = (k == ex1) || (k == ex2);
            abort = (k == abort_cyc);
            if (k == abort_cyc) aborted = 1'b1;
            sb.push_back(aborted ? mk(0, 0, 0, 0) : tl[k+1]);
            @(posedge clk); #1;
            start = 1'b0;
            abort = 1'b0;
            pop_check(ctx);
        end
    endtask

    task automatic abort_to_idle(input string ctx);
        abort = 1'b1;
        @(posedge clk); #1;
        abort = 1'b0;
        check_zero(ctx);
    endtask

    initial begin
`ifdef MELODY_LOOP_EN
        build_timeline(1'b1);
`else
        build_timeline(1'b0);
`endif
        // Reset state while reset is held.
        #12;
        check_zero("reset");
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("post_reset");

        // Whole melody from a clean start, plus idle cycles afterwards.
        run(100, -1, -1, -1, "clean");
        abort_to_idle("idle1");

        // Stray start pulses in cycle 10 and in the done/wrap cycle.
        run(100, -1, 10, 93, "extra_start");
        abort_to_idle("idle2");

        // Abort during a note, then a fresh start from index 0.
        run(40, 30, -1, -1, "abort");
        run(12, -1, -1, -1, "rerun");
        abort_to_idle("idle3");

        // start and abort together while idle.
        start = 1'b1;
        abort = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        abort = 1'b0;
        check_zero("start_abort");
        @(posedge clk); #1;
        check_zero("start_abort_hold");

        // Asynchronous reset in the middle of a note.
        run(20, -1, -1, -1, "pre_reset");
        #3;
        rst = 1'b0;
        #1;
        check_zero("async_reset");
        #2;
        rst = 1'b1;
        @(posedge clk); #1;
        check_zero("after_reset");

        chk("sb_left", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
